// File: rtl/rsf_pkg.sv
// rtl/rsf_pkg.sv - shared policy codes and next-state rule for the RS flip-flop bank
package rsf_pkg;

    localparam int INV_HOLD   = 0;
    localparam int INV_RESET  = 1;
    localparam int INV_SET    = 2;
    localparam int INV_TOGGLE = 3;

    // Policy codes outside the known set fall back to hold.
    function automatic logic next_q(input logic q, input logic s, input logic r, input int mode);
        logic nxt;
        nxt = q;
        if (s && r) begin
            case (mode)
                INV_RESET:  nxt = 1'b0;
                INV_SET:    nxt = 1'b1;
                INV_TOGGLE: nxt = ~q;
                default:    nxt = q;
            endcase
        end else if (s) begin
            nxt = 1'b1;
        end else if (r) begin
            nxt = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rsf_cell.sv
// rtl/rsf_cell.sv - single clocked RS storage bit with forbidden-input flag
module rsf_cell
    import rsf_pkg::*;
#(
    parameter int INVALID_MODE = INV_HOLD,
    parameter bit RESET_Q      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic S,
    input  logic R,
    output logic Q,
    output logic nQ,
    output logic invalid
);

    logic q_reg;
    logic invalid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= RESET_Q;
            invalid_reg <= 1'b0;
        end else begin
            q_reg       <= next_q(q_reg, S, R, INVALID_MODE);
            invalid_reg <= S & R;
        end
    end

    // nQ derives from the register, so it can never disagree with Q.
    assign Q       = q_reg;
    assign nQ      = ~q_reg;
    assign invalid = invalid_reg;

endmodule

// File: rtl/rs_flip_flop.sv
// rtl/rs_flip_flop.sv - bank of WIDTH independent clocked RS flip-flops
module rs_flip_flop
    import rsf_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int INVALID_MODE = INV_HOLD,
    parameter bit RESET_Q      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic [WIDTH-1:0] invalid
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rsf_cell #(
            .INVALID_MODE(INVALID_MODE),
            .RESET_Q     (RESET_Q)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .S      (S[i]),
            .R      (R[i]),
            .Q      (Q[i]),
            .nQ     (nQ[i]),
            .invalid(invalid[i])
        );
    end

endmodule

// File: tb/tb_rs_flip_flop.sv
// tb/tb_rs_flip_flop.sv - scoreboard bench for rs_flip_flop across all invalid-input policies
module tb_rs_flip_flop;

    localparam int W  = 4;
    localparam int NI = 5;
    localparam int MODE_OF [NI] = '{0, 1, 2, 3, 7};
    localparam bit RSTQ_OF [NI] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    logic clk;
    logic rst;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] q   [NI];
    logic [W-1:0] nq  [NI];
    logic [W-1:0] inv [NI];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [NI-1:0][W-1:0] q;
        logic [NI-1:0][W-1:0] inv;
    } exp_t;

    exp_t sb[$];
    logic [W-1:0] m_q [NI];

    rs_flip_flop #(.WIDTH(W), .INVALID_MODE(0), .RESET_Q(1'b0)) u_m0 (
        .clk(clk), .rst(rst), .R(r), .S(s), .Q(q[0]), .nQ(nq[0]), .invalid(inv[0]));
    rs_flip_flop #(.WIDTH(W), .INVALID_MODE(1), .RESET_Q(1'b0)) u_m1 (
        .clk(clk), .rst(rst), .R(r), .S(s), .Q(q[1]), .nQ(nq[1]), .invalid(inv[1]));
    rs_flip_flop #(.WIDTH(W), .INVALID_MODE(2), .RESET_Q(1'b0)) u_m2 (
        .clk(clk), .rst(rst), .R(r), .S(s), .Q(q[2]), .nQ(nq[2]), .invalid(inv[2]));
    rs_flip_flop #(.WIDTH(W), .INVALID_MODE(3), .RESET_Q(1'b0)) u_m3 (
        .clk(clk), .rst(rst), .R(r), .S(s), .Q(q[3]), .nQ(nq[3]), .invalid(inv[3]));
    rs_flip_flop #(.WIDTH(W), .INVALID_MODE(7), .RESET_Q(1'b1)) u_m7 (
        .clk(clk), .rst(rst), .R(r), .S(s), .Q(q[4]), .nQ(nq[4]), .invalid(inv[4]));

    initial begin
        clk = 1'b0;
        forever #70 clk = ~clk;
    end

    // Reference: table of outcomes indexed by {S,R}; forbidden row picks by policy.
    function automatic logic ref_bit(input logic cur, input logic sb_, input logic rb, input int mode);
        int idx;
        idx = (sb_ ? 2 : 0) + (rb ? 1 : 0);
        if (idx == 0) return cur;
        if (idx == 1) return 1'b0;
        if (idx == 2) return 1'b1;
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        if (mode == 3) return !cur;
        return cur;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            for (int b = 0; b < W; b++) begin
                if (rst) begin
                    m_q[k][b]  = RSTQ_OF[k];
                    e.inv[k][b] = 1'b0;
                end else begin
                    m_q[k][b]  = ref_bit(m_q[k][b], s[b], r[b], MODE_OF[k]);
                    e.inv[k][b] = s[b] & r[b];
                end
            end
            e.q[k] = m_q[k];
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int k = 0; k < NI; k++) begin
                checks++;
                if (q[k] !== e.q[k]) begin
                    errors++;
                    $display("FAIL q[%0d] at %0t: got %b expected %b", k, $time, q[k], e.q[k]);
                end
                checks++;
                if (nq[k] !== ~e.q[k]) begin
                    errors++;
                    $display("FAIL nq[%0d] at %0t: got %b expected %b", k, $time, nq[k], ~e.q[k]);
                end
                checks++;
                if (inv[k] !== e.inv[k]) begin
                    errors++;
                    $display("FAIL invalid[%0d] at %0t: got %b expected %b", k, $time, inv[k], e.inv[k]);
                end
            end
        end
    end

    // Outputs may only move at a rising edge (posedges fall at 70 mod 140).
    always @(q[0] or q[3] or q[4]) begin
        if ($time > 0) begin
            checks++;
            if ($time % 140 != 70) begin
                errors++;
                $display("FAIL q_edge_only: change at %0t, expected only at rising edges", $time);
            end
        end
    end

    task automatic step(input logic rst_v, input logic [W-1:0] s_v, input logic [W-1:0] r_v);
        @(negedge clk);
        rst = rst_v;
        s   = s_v;
        r   = r_v;
    endtask

    initial begin
        rst = 1'b1;
        s   = '1;
        r   = '0;
        // Reset with a pending set, then the basic truth table and forbidden-input policies.
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b0, 4'b0001, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0001);
        step(1'b0, 4'b0001, 4'b0000);
        step(1'b0, 4'b0001, 4'b0001);
        step(1'b0, 4'b0001, 4'b0001);
        step(1'b0, 4'b0000, 4'b0000);
        // Multi-bit example from all-zero state.
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0101, 4'b0011);
        @(posedge clk);
        #1;
        checks++;
        if (q[0] !== 4'b0100 || inv[0] !== 4'b0001) begin
            errors++;
            $display("FAIL multibit: got q=%b invalid=%b expected q=0100 invalid=0001", q[0], inv[0]);
        end
        // Mid-operation reset overriding a set, then recovery.
        step(1'b0, 4'b1111, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b0, 4'b1111, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        // Randomised traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), W'($urandom), W'($urandom));
        end
        // Inputs toggling out of phase with the clock, never on an edge.
        step(1'b0, 4'b0000, 4'b0000);
        fork
            begin
                #5;
                repeat (33) begin
                    #30 r = ~r;
                end
            end
            begin
                #5;
                repeat (20) begin
                    #50 s = ~s;
                end
            end
        join
        step(1'b0, 4'b0000, 4'b0000);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
